ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_ex_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU, branch resolution and an optional radix-2 divider.
// Define EX_DIV_EN to build the divider FSM; without it div_op is ignored and stallreq_ex is 0.

`ifndef StallBus
`define StallBus 6
`endif
`ifndef ID2EX_WD
`define ID2EX_WD 203
`endif
`ifndef EX2MEM1_WD
`define EX2MEM1_WD 147
`endif
`ifndef BYPASS_WD
`define BYPASS_WD 38
`endif

module ex_stage (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`StallBus-1:0]   stall,
    input  logic [`ID2EX_WD-1:0]   id2ex_bus,
    output logic [`EX2MEM1_WD-1:0] ex2mem1_bus,
    output logic [`BYPASS_WD-1:0]  ex2rf_bus,
    output logic                   br_e,
    output logic [31:0]            br_addr,
    output logic                   stallreq_ex
);
    logic [`ID2EX_WD-1:0] ex_q, ex_d;

    logic [31:0] src1, src2, imm, pc, inst;
    logic [11:0] alu_op;
    logic [7:0]  bru_op, lsu_op;
    logic [3:0]  mul_op, div_op;
    logic        sel_rf_res, rf_we;
    logic [4:0]  rf_waddr;

    logic [31:0] alu_res, ex_result, br_target, jalr_sum, div_res;
    logic        eq, lt_s, lt_u, cond, taken, div_act;
    logic [4:0]  sh;
    logic        stall_unused;

    assign stall_unused = ^{stall[`StallBus-1:5], stall[2:0]};

    // Bubble wins over load so a redirecting branch squashes the instruction behind it.
    always_comb begin
        ex_d = ex_q;
        if ((stall[3] && !stall[4]) || br_e)
            ex_d = '0;
        else if (!stall[3])
            ex_d = id2ex_bus;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign {src1, src2, imm, alu_op, bru_op, lsu_op, mul_op, div_op,
            sel_rf_res, rf_we, rf_waddr, pc, inst} = ex_q;

    assign sh = src2[4:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            12'h001: alu_res = src1 + src2;
            12'h002: alu_res = src1 - src2;
            12'h004: alu_res = {31'd0, lt_s};
            12'h008: alu_res = {31'd0, lt_u};
            12'h010: alu_res = src1 & src2;
            12'h020: alu_res = src1 | src2;
            12'h040: alu_res = src1 ^ src2;
            12'h080: alu_res = src1 << sh;
            12'h100: alu_res = src1 >> sh;
            12'h200: alu_res = $signed(src1) >>> sh;
            12'h400: alu_res = src2;
            default: alu_res = '0;
        endcase
    end

    assign eq   = (src1 == src2);
    assign lt_s = ($signed(src1) < $signed(src2));
    assign lt_u = (src1 < src2);

    assign cond = (bru_op[0] & eq)   | (bru_op[1] & !eq)   |
                  (bru_op[2] & lt_s) | (bru_op[3] & !lt_s) |
                  (bru_op[4] & lt_u) | (bru_op[5] & !lt_u);
    assign taken    = cond | bru_op[6] | bru_op[7];
    assign jalr_sum = src1 + imm;
    assign br_target = bru_op[7] ? (jalr_sum & ~32'd1) : (pc + imm);

    assign br_e    = taken & !stall[3] & !stallreq_ex;
    assign br_addr = br_e ? br_target : 32'd0;

    always_comb begin
        if (bru_op[6] || bru_op[7])
            ex_result = pc + 32'd4;
        else if (div_act)
            ex_result = div_res;
        else
            ex_result = alu_res;
    end

    assign ex2mem1_bus = {ex_result, src2, lsu_op, mul_op, sel_rf_res, rf_we, rf_waddr, pc, inst};
    assign ex2rf_bus   = {rf_we, rf_waddr, ex_result};

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic        negq_q, negq_d, negr_q, negr_d;

    logic        is_signed, div_zero, div_ovf, fit;
    logic [31:0] abs1, abs2, rem_nxt, quot_nxt;
    logic [32:0] rem_sh, diff;

    assign div_act   = |div_op;
    assign is_signed = div_op[0] | div_op[2];
    assign div_zero  = (src2 == 32'd0);
    assign div_ovf   = is_signed & (src1 == 32'h8000_0000) & (src2 == 32'hFFFF_FFFF);
    assign abs1      = (is_signed && src1[31]) ? -src1 : src1;
    assign abs2      = (is_signed && src2[31]) ? -src2 : src2;

    // Restoring step: the dividend shifts out of quot_q into the partial remainder.
    assign rem_sh   = {rem_q, quot_q[31]};
    assign diff     = rem_sh - {1'b0, dvsr_q};
    assign fit      = !diff[32];
    assign rem_nxt  = fit ? diff[31:0] : rem_sh[31:0];
    assign quot_nxt = {quot_q[30:0], fit};

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= DIV_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (div_act) state_d = (div_zero || div_ovf) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (!div_act)
                    state_d = DIV_IDLE;
                else if (cnt_q == 5'd31)
                    state_d = DIV_DONE;
            end
            DIV_DONE: if (!stall[3]) state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        stallreq_ex = div_act && (state_q != DIV_DONE);
    end

    always_comb begin
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dvsr_d = dvsr_q;
        negq_d = negq_q;
        negr_d = negr_q;
        case (state_q)
            DIV_IDLE: begin
                if (div_act) begin
                    cnt_d = 5'd0;
                    if (div_zero) begin
                        quot_d = 32'hFFFF_FFFF;
                        rem_d  = src1;
                    end else if (div_ovf) begin
                        quot_d = 32'h8000_0000;
                        rem_d  = 32'd0;
                    end else begin
                        quot_d = abs1;
                        rem_d  = 32'd0;
                        dvsr_d = abs2;
                        negq_d = is_signed & (src1[31] ^ src2[31]);
                        negr_d = is_signed & src1[31];
                    end
                end
            end
            DIV_BUSY: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    quot_d = negq_q ? -quot_nxt : quot_nxt;
                    rem_d  = negr_q ? -rem_nxt : rem_nxt;
                end else begin
                    quot_d = quot_nxt;
                    rem_d  = rem_nxt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end

    assign div_res = (div_op[2] | div_op[3]) ? rem_q : quot_q;
`else
    logic div_op_unused;

    assign div_op_unused = |div_op;
    assign div_act       = 1'b0;
    assign div_res       = 32'd0;
    assign stallreq_ex   = 1'b0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: ALU/branch table plus divider, stall and reset sequences.

`ifndef StallBus
`define StallBus 6
`endif
`ifndef ID2EX_WD
`define ID2EX_WD 203
`endif
`ifndef EX2MEM1_WD
`define EX2MEM1_WD 147
`endif
`ifndef BYPASS_WD
`define BYPASS_WD 38
`endif

module tb_ex_stage;
    localparam logic [31:0] INST = 32'h1234_5678;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [`StallBus-1:0]   stall, stall_ext;
    logic [`ID2EX_WD-1:0]   id2ex_bus;
    logic [`EX2MEM1_WD-1:0] ex2mem1_bus;
    logic [`BYPASS_WD-1:0]  ex2rf_bus;
    logic                   br_e;
    logic [31:0]            br_addr;
    logic                   stallreq_ex;
    logic [31:0]            ex_result;

    int n_tests = 0;
    int n_fail  = 0;

    ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .id2ex_bus   (id2ex_bus),
        .ex2mem1_bus (ex2mem1_bus),
        .ex2rf_bus   (ex2rf_bus),
        .br_e        (br_e),
        .br_addr     (br_addr),
        .stallreq_ex (stallreq_ex)
    );

    always #5 clk = ~clk;

    // Pipeline controller model: an EX stall request holds PC..MEM1.
    assign stall     = stall_ext | (stallreq_ex ? 6'b011111 : 6'b000000);
    assign ex_result = ex2mem1_bus[`EX2MEM1_WD-1 -: 32];

    typedef struct {
        string       name;
        logic [31:0] s1, s2, imm;
        logic [11:0] alu;
        logic [7:0]  bru;
        logic [31:0] pc, res;
        logic        bre;
        logic [31:0] baddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input string nm, input logic [31:0] s1, s2, im,
                                 input logic [11:0] a, input logic [7:0] b,
                                 input logic [31:0] p, r, input logic be, input logic [31:0] ba);
        vec_t v;
        v.name = nm; v.s1 = s1; v.s2 = s2; v.imm = im; v.alu = a; v.bru = b;
        v.pc = p; v.res = r; v.bre = be; v.baddr = ba;
        return v;
    endfunction

    function automatic logic [`ID2EX_WD-1:0] mk(input logic [31:0] s1, s2, im,
                                                input logic [11:0] a, input logic [7:0] b,
                                                input logic [3:0] dv, input logic [4:0] rd,
                                                input logic [31:0] p);
        return {s1, s2, im, a, b, 8'hA5, 4'h3, dv, 1'b1, 1'b1, rd, p, INST};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_div(input string nm, input logic [31:0] s1, s2, input logic [3:0] dv,
                           input int exp_cyc, input logic [31:0] exp_res, input int hold);
        int cyc = 0;
        @(negedge clk);
        id2ex_bus = mk(s1, s2, 32'd0, 12'h000, 8'h00, dv, 5'd9, 32'h40);
        @(posedge clk); #1;
        while (stallreq_ex && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
        check($sformatf("%s_stall_cycles", nm), 256'(cyc), 256'(exp_cyc));
        check($sformatf("%s_result", nm), 256'(ex_result), 256'(exp_res));
        if (hold > 0) begin
            @(negedge clk);
            stall_ext = 6'b011000;
            repeat (hold) @(posedge clk);
            #1;
            check($sformatf("%s_done_hold", nm), 256'({stallreq_ex, ex_result}), 256'({1'b0, exp_res}));
            @(negedge clk);
            stall_ext = '0;
        end
        @(negedge clk);
        id2ex_bus = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        stall_ext = '0;
        id2ex_bus = mk(32'd5, 32'd7, 32'd0, 12'h001, 8'h00, 4'h0, 5'd3, 32'h10);

        // ALU table (alu_op index: add,sub,slt,sltu,and,or,xor,sll,srl,sra,lui) and branches.
        vecs.push_back(mkv("add",   32'd5,        32'd7,        32'd0, 12'h001, 8'h00, 32'h10, 32'd12,       1'b0, 32'd0));
        vecs.push_back(mkv("sub",   32'd5,        32'd7,        32'd0, 12'h002, 8'h00, 32'h14, 32'hFFFFFFFE, 1'b0, 32'd0));
        vecs.push_back(mkv("slt",   32'hFFFFFFFF, 32'd1,        32'd0, 12'h004, 8'h00, 32'h18, 32'd1,        1'b0, 32'd0));
        vecs.push_back(mkv("sltu",  32'hFFFFFFFF, 32'd1,        32'd0, 12'h008, 8'h00, 32'h1C, 32'd0,        1'b0, 32'd0));
        vecs.push_back(mkv("and",   32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 12'h010, 8'h00, 32'h20, 32'hF000F000, 1'b0, 32'd0));
        vecs.push_back(mkv("or",    32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 12'h020, 8'h00, 32'h24, 32'hFFF0FFF0, 1'b0, 32'd0));
        vecs.push_back(mkv("xor",   32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 12'h040, 8'h00, 32'h28, 32'h0FF00FF0, 1'b0, 32'd0));
        vecs.push_back(mkv("sll",   32'd1,        32'h23,       32'd0, 12'h080, 8'h00, 32'h2C, 32'd8,        1'b0, 32'd0));
        vecs.push_back(mkv("srl",   32'h80000000, 32'd4,        32'd0, 12'h100, 8'h00, 32'h30, 32'h08000000, 1'b0, 32'd0));
        vecs.push_back(mkv("sra",   32'h80000000, 32'd4,        32'd0, 12'h200, 8'h00, 32'h34, 32'hF8000000, 1'b0, 32'd0));
        vecs.push_back(mkv("lui",   32'd99,       32'h12345000, 32'd0, 12'h400, 8'h00, 32'h38, 32'h12345000, 1'b0, 32'd0));
        vecs.push_back(mkv("noop",  32'd5,        32'd7,        32'd0, 12'h000, 8'h00, 32'h3C, 32'd0,        1'b0, 32'd0));
        vecs.push_back(mkv("blt",   32'hFFFFFFFF, 32'd1,  32'h20,       12'h000, 8'h04, 32'h100, 32'd0,      1'b1, 32'h120));
        vecs.push_back(mkv("bltu",  32'hFFFFFFFF, 32'd1,  32'h20,       12'h000, 8'h10, 32'h100, 32'd0,      1'b0, 32'd0));
        vecs.push_back(mkv("beq",   32'd5,        32'd5,  32'hFFFFFFF0, 12'h000, 8'h01, 32'h200, 32'd0,      1'b1, 32'h1F0));
        vecs.push_back(mkv("bne",   32'd5,        32'd5,  32'h10,       12'h000, 8'h02, 32'h200, 32'd0,      1'b0, 32'd0));
        vecs.push_back(mkv("bge",   32'd1,        32'hFFFFFFFF, 32'h8,  12'h000, 8'h08, 32'h300, 32'd0,      1'b1, 32'h308));
        vecs.push_back(mkv("bgeu",  32'd1,        32'hFFFFFFFF, 32'h8,  12'h000, 8'h20, 32'h300, 32'd0,      1'b0, 32'd0));
        vecs.push_back(mkv("jal",   32'd0,        32'd0,  32'h10,       12'h000, 8'h40, 32'h400, 32'h404,    1'b1, 32'h410));
        vecs.push_back(mkv("jalr",  32'h203,      32'd0,  32'h4,        12'h000, 8'h80, 32'h80,  32'h84,     1'b1, 32'h206));

        // Reset clears EX even with a live instruction on the input.
        repeat (3) @(posedge clk);
        #1;
        check("reset_ex2mem1", 256'(ex2mem1_bus), 256'd0);
        check("reset_ex2rf", 256'(ex2rf_bus), 256'd0);
        check("reset_br", 256'({br_e, br_addr}), 256'd0);
        check("reset_stallreq", 256'(stallreq_ex), 256'd0);
        @(negedge clk);
        rst       = 1'b0;
        id2ex_bus = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            logic [4:0] rd;
            rd = 5'(i + 1);
            @(negedge clk);
            id2ex_bus = mk(vecs[i].s1, vecs[i].s2, vecs[i].imm, vecs[i].alu, vecs[i].bru, 4'h0, rd, vecs[i].pc);
            @(posedge clk); #1;
            check({vecs[i].name, "_bus"}, 256'(ex2mem1_bus),
                  256'({vecs[i].res, vecs[i].s2, 8'hA5, 4'h3, 1'b1, 1'b1, rd, vecs[i].pc, INST}));
            check({vecs[i].name, "_rf"}, 256'(ex2rf_bus), 256'({1'b1, rd, vecs[i].res}));
            check({vecs[i].name, "_br_e"}, 256'(br_e), 256'(vecs[i].bre));
            check({vecs[i].name, "_br_addr"}, 256'(br_addr), 256'(vecs[i].baddr));
            @(negedge clk);
            id2ex_bus = '0;
            @(posedge clk);
        end

        // Taken branch squashes the following instruction; br_e lasts one cycle.
        @(negedge clk);
        id2ex_bus = mk(32'hFFFFFFFF, 32'd1, 32'h20, 12'h000, 8'h04, 4'h0, 5'd4, 32'h100);
        @(posedge clk); #1;
        check("blt_seq_pulse", 256'({br_e, br_addr}), 256'({1'b1, 32'h120}));
        @(negedge clk);
        id2ex_bus = mk(32'd5, 32'd7, 32'd0, 12'h001, 8'h00, 4'h0, 5'd3, 32'h104);
        @(posedge clk); #1;
        check("blt_seq_bubble", 256'(ex2mem1_bus), 256'd0);
        check("blt_seq_br_off", 256'(br_e), 256'd0);
        @(posedge clk); #1;
        check("blt_seq_next_add", 256'(ex_result), 256'd12);

        // A held EX stage suppresses the redirect until released.
        @(negedge clk);
        id2ex_bus = mk(32'd5, 32'd5, 32'h40, 12'h000, 8'h01, 4'h0, 5'd1, 32'h500);
        @(posedge clk); #1;
        stall_ext = 6'b011000;
        #1;
        check("beq_held_no_br", 256'(br_e), 256'd0);
        @(posedge clk); #1;
        check("beq_held_keeps", 256'(ex2mem1_bus[63:32]), 256'(32'h500));
        stall_ext = '0;
        #1;
        check("beq_released_br", 256'({br_e, br_addr}), 256'({1'b1, 32'h540}));
        @(negedge clk);
        id2ex_bus = '0;
        @(posedge clk);

        // EX hold with MEM1 moving inserts a bubble.
        @(negedge clk);
        id2ex_bus = mk(32'd5, 32'd7, 32'd0, 12'h001, 8'h00, 4'h0, 5'd3, 32'h10);
        @(posedge clk); #1;
        stall_ext = 6'b001000;
        @(posedge clk); #1;
        check("ex_bubble", 256'(ex2mem1_bus), 256'd0);
        stall_ext = '0;
        id2ex_bus = '0;
        @(posedge clk);

`ifdef EX_DIV_EN
        run_div("div",    32'hFFFFFFF9, 32'd2,        4'b0001, 33, 32'hFFFFFFFD, 3);
        run_div("rem",    32'hFFFFFFF9, 32'd2,        4'b0100, 33, 32'hFFFFFFFF, 0);
        run_div("divu_z", 32'd1234,     32'd0,        4'b0010, 1,  32'hFFFFFFFF, 0);
        run_div("remu_z", 32'd7,        32'd0,        4'b1000, 1,  32'd7,        0);
        run_div("div_ov", 32'h80000000, 32'hFFFFFFFF, 4'b0001, 1,  32'h80000000, 0);
        run_div("rem_ov", 32'h80000000, 32'hFFFFFFFF, 4'b0100, 1,  32'd0,        0);
        run_div("remu",   32'hFFFFFFFF, 32'd10,       4'b1000, 33, 32'd5,        0);

        // Reset in the 10th BUSY cycle aborts cleanly.
        @(negedge clk);
        id2ex_bus = mk(32'hFFFFFFF9, 32'd2, 32'd0, 12'h000, 8'h00, 4'b0001, 5'd9, 32'h40);
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy", 256'(stallreq_ex), 256'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_stallreq", 256'(stallreq_ex), 256'd0);
        check("abort_outputs", 256'({ex2mem1_bus, ex2rf_bus, br_e, br_addr}), 256'd0);
        rst       = 1'b0;
        id2ex_bus = '0;
        run_div("divu_after", 32'd100, 32'd7, 4'b0010, 33, 32'd14, 0);
`else
        // Without the divider, div_op is ignored and the ALU result passes.
        @(negedge clk);
        id2ex_bus = mk(32'hFFFFFFF9, 32'd2, 32'd0, 12'h001, 8'h00, 4'b0001, 5'd9, 32'h40);
        @(posedge clk); #1;
        check("nodiv_stallreq", 256'(stallreq_ex), 256'd0);
        check("nodiv_result", 256'(ex_result), 256'(32'hFFFFFFFB));
        @(negedge clk);
        id2ex_bus = mk(32'd1234, 32'd0, 32'd0, 12'h002, 8'h00, 4'b0010, 5'd9, 32'h44);
        @(posedge clk); #1;
        check("nodiv_zero_result", 256'({stallreq_ex, ex_result}), 256'({1'b0, 32'd1234}));
        @(negedge clk);
        id2ex_bus = '0;
        @(posedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
